// File: rtl/conv_kernel_pkg.sv
// conv_kernel_pkg: binary32 field constants, the float field struct and a
// leading-zero counter used by the adder normaliser.
package conv_kernel_pkg;

   localparam int unsigned SIGN_W = 1;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MAN_W  = 23;
   localparam int unsigned FP_W   = SIGN_W + EXP_W + MAN_W;

   localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
   localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
   localparam logic [FP_W-1:0]  QNAN     = 32'h7FC00000;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [MAN_W-1:0]  man;
   } fp32_t;

   // Count of leading zeros in a 28-bit word (28 when the word is zero).
   function automatic logic [4:0] lzc28(input logic [27:0] v);
      logic [4:0] n;
      n = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (v[i]) n = 5'(27 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_mul32.sv
// fp_mul32: combinational binary32 multiplier, round-toward-zero,
// denormals flushed to signed zero.
//   a, b       : binary32 operands
//   product_c  : binary32 product (combinational)
module fp_mul32
   import conv_kernel_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] product_c
);

   fp32_t       fa, fb, r;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [47:0] sig_prod;
   logic [9:0]  e_sum;
   logic        unused_bits;

   assign fa = fp32_t'(a);
   assign fb = fp32_t'(b);

   assign a_zero = (fa.exp == '0);
   assign b_zero = (fb.exp == '0);
   assign a_inf  = (fa.exp == EXP_MAX) && (fa.man == '0);
   assign b_inf  = (fb.exp == EXP_MAX) && (fb.man == '0);
   assign a_nan  = (fa.exp == EXP_MAX) && (fa.man != '0);
   assign b_nan  = (fb.exp == EXP_MAX) && (fb.man != '0);

   assign sig_prod = 48'({1'b1, fa.man}) * 48'({1'b1, fb.man});
   // Biased exponent sum including the one-place normalisation carry.
   assign e_sum    = 10'(fa.exp) + 10'(fb.exp) + 10'(sig_prod[47]);
   assign unused_bits = ^sig_prod[22:0];

   // Special-case priority, then normal path with truncated significand.
   always_comb begin
      r      = '0;
      r.sign = fa.sign ^ fb.sign;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         r = fp32_t'(QNAN);
      end else if (a_inf || b_inf) begin
         r.exp = EXP_MAX;
      end else if (a_zero || b_zero) begin
         r.exp = '0;
      end else if (e_sum <= 10'(EXP_BIAS)) begin
         r.exp = '0;
      end else if (e_sum >= 10'(EXP_BIAS) + 10'(EXP_MAX)) begin
         r.exp = EXP_MAX;
      end else begin
         r.exp = 8'(e_sum - 10'(EXP_BIAS));
         r.man = sig_prod[47] ? sig_prod[46:24] : sig_prod[45:23];
      end
   end

   assign product_c = FP_W'(r);

endmodule

// File: rtl/conv_kernel.sv
// conv_kernel: continuous binary32 multiply-accumulate. Stage 1 registers
// pixel*weight, stage 2 adds it into the running sum driven on o_pixel.
//   clk, rst_n : clock, async active-low reset
//   i_pixel    : binary32 pixel operand
//   i_weight   : binary32 weight operand
//   o_pixel    : registered running sum (binary32)
module conv_kernel
   import conv_kernel_pkg::*;
#(
   parameter int unsigned WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_pixel,
   input  logic [WIDTH-1:0] i_weight,
   output logic [WIDTH-1:0] o_pixel
);

   logic [WIDTH-1:0] prod_c;
   logic [WIDTH-1:0] p_reg;
   fp32_t            sum_c;

   fp_mul32 u_mul (
      .a         (i_pixel),
      .b         (i_weight),
      .product_c (prod_c)
   );

   // Pipeline registers: product, then accumulator (which is o_pixel).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg   <= '0;
         o_pixel <= '0;
      end else begin
         p_reg   <= prod_c;
         o_pixel <= WIDTH'(sum_c);
      end
   end

   // Adder datapath: larger magnitude first, 3 extra bits + sticky on the
   // aligned operand so truncation stays exact under subtraction.
   fp32_t       fa, fb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic        a_ge, eff_sub;
   logic        big_sign;
   logic [7:0]  big_exp, small_exp, diff;
   logic [22:0] big_man, small_man;
   logic [49:0] wide;
   logic [26:0] big_al, small_al;
   logic [27:0] mag, norm;
   logic [4:0]  lz;
   logic [9:0]  e_top;
   logic        unused_norm;

   assign fa = fp32_t'(o_pixel);
   assign fb = fp32_t'(p_reg);

   assign a_zero = (fa.exp == '0);
   assign b_zero = (fb.exp == '0);
   assign a_inf  = (fa.exp == EXP_MAX) && (fa.man == '0);
   assign b_inf  = (fb.exp == EXP_MAX) && (fb.man == '0);
   assign a_nan  = (fa.exp == EXP_MAX) && (fa.man != '0);
   assign b_nan  = (fb.exp == EXP_MAX) && (fb.man != '0);

   assign a_ge      = {fa.exp, fa.man} >= {fb.exp, fb.man};
   assign big_sign  = a_ge ? fa.sign : fb.sign;
   assign big_exp   = a_ge ? fa.exp  : fb.exp;
   assign big_man   = a_ge ? fa.man  : fb.man;
   assign small_exp = a_ge ? fb.exp  : fa.exp;
   assign small_man = a_ge ? fb.man  : fa.man;
   assign eff_sub   = fa.sign ^ fb.sign;

   assign diff     = big_exp - small_exp;
   assign wide     = {1'b1, small_man, 26'd0} >> diff;
   assign big_al   = {1'b1, big_man, 3'b000};
   // Beyond 26 places the whole smaller significand collapses into sticky.
   assign small_al = (diff > 8'd26) ? 27'd1 : {wide[49:24], |wide[23:0]};

   assign mag   = eff_sub ? (28'(big_al) - 28'(small_al))
                          : (28'(big_al) + 28'(small_al));
   assign lz    = lzc28(mag);
   assign norm  = mag << lz;
   assign e_top = 10'(big_exp) + 10'd1;
   assign unused_norm = ^{norm[27], norm[3:0]};

   // Special-case priority, then normalised, truncated sum.
   always_comb begin
      sum_c = '0;
      if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
         sum_c = fp32_t'(QNAN);
      end else if (a_inf) begin
         sum_c = fa;
      end else if (b_inf) begin
         sum_c = fb;
      end else if (a_zero && b_zero) begin
         sum_c.sign = fa.sign & fb.sign;
      end else if (a_zero) begin
         sum_c = fb;
      end else if (b_zero) begin
         sum_c = fa;
      end else if (mag == '0) begin
         sum_c = '0;
      end else if (e_top <= 10'(lz)) begin
         sum_c.sign = big_sign;
      end else if (e_top - 10'(lz) >= 10'(EXP_MAX)) begin
         sum_c.sign = big_sign;
         sum_c.exp  = EXP_MAX;
      end else begin
         sum_c.sign = big_sign;
         sum_c.exp  = 8'(e_top - 10'(lz));
         sum_c.man  = norm[26:4];
      end
   end

endmodule

// File: tb/tb_conv_kernel.sv
// tb_conv_kernel: directed and randomized checks of the binary32 MAC.
module tb_conv_kernel;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_pixel;
   logic [31:0] i_weight;
   logic [31:0] o_pixel;

   int total;
   int bad;

   conv_kernel #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_pixel  (i_pixel),
      .i_weight (i_weight),
      .o_pixel  (o_pixel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] dp_px  [9] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000,
                               32'h40E00000, 32'h41000000, 32'h41100000};
   logic [31:0] dp_wt  [9] = '{32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000,
                               32'h41000000, 32'h41100000, 32'h3F800000};
   logic [31:0] dp_exp [9] = '{32'h40000000, 32'h41000000, 32'h41A00000,
                               32'h42200000, 32'h428C0000, 32'h42E00000,
                               32'h43280000, 32'h43700000, 32'h43790000};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", tag, got, want);
      end
   endtask

   // New pair applied at the falling edge; sampled by the next rising edge.
   task automatic drive(input logic [31:0] px, input logic [31:0] wt);
      @(negedge clk);
      i_pixel  = px;
      i_weight = wt;
   endtask

   task automatic flush_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      i_pixel  = '0;
      i_weight = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Exact binary32 encoding of n / 2**fb (|n| < 2**24).
   function automatic logic [31:0] to_fp(input int n, input int fb);
      int          mag;
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      mag = (n < 0) ? -n : n;
      p   = 0;
      for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
      m = 32'(mag) << (23 - p);
      return {(n < 0), 8'(p - fb + 127), m[22:0]};
   endfunction

   initial begin
      int q[$];
      int sum;
      int p;
      int k;

      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      i_pixel  = '0;
      i_weight = '0;
      #3 check("reset_init", o_pixel, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         drive(32'h0, 32'h0);
         check("idle_zero", o_pixel, 32'h0);
      end

      // 3x3 dot product: output lags the pair by two falling edges here.
      for (int i = 0; i < 9; i++) begin
         drive(dp_px[i], dp_wt[i]);
         if (i >= 2) check($sformatf("dot%0d", i - 2), o_pixel, dp_exp[i-2]);
      end
      drive(32'h0, 32'h0);
      check("dot7", o_pixel, dp_exp[7]);
      drive(32'h0, 32'h0);
      check("dot8", o_pixel, dp_exp[8]);
      repeat (10) begin
         drive(32'h0, 32'h0);
         check("hold", o_pixel, 32'h43790000);
      end

      // Asynchronous reset between edges.
      #2 rst_n = 1'b0;
      #1 check("async_rst", o_pixel, 32'h0);
      @(posedge clk);
      #1 check("rst_held", o_pixel, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         drive(32'h0, 32'h0);
         check("post_rst_zero", o_pixel, 32'h0);
      end

      // Signed cancellation gives +0.
      drive(32'h40000000, 32'h40400000);
      drive(32'hC0000000, 32'h40400000);
      drive(32'h0, 32'h0);
      check("cancel_6", o_pixel, 32'h40C00000);
      drive(32'h0, 32'h0);
      check("cancel_zero", o_pixel, 32'h0);

      // Multiplier truncation: (1+2^-23)^2.
      drive(32'h3F800001, 32'h3F800001);
      drive(32'h0, 32'h0);
      drive(32'h0, 32'h0);
      check("mul_trunc", o_pixel, 32'h3F800002);

      // Adder truncation under subtraction: 1 - 2^-25.
      flush_reset();
      drive(32'h3F800000, 32'h3F800000);
      drive(32'hB3000000, 32'h3F800000);
      drive(32'h0, 32'h0);
      check("sub_one", o_pixel, 32'h3F800000);
      drive(32'h0, 32'h0);
      check("sub_trunc", o_pixel, 32'h3F7FFFFF);

      // Adder truncation under addition: 1 + 2^-24.
      flush_reset();
      drive(32'h3F800000, 32'h3F800000);
      drive(32'h33800000, 32'h3F800000);
      drive(32'h0, 32'h0);
      drive(32'h0, 32'h0);
      check("add_trunc", o_pixel, 32'h3F800000);

      // Product underflow flushes to zero.
      flush_reset();
      drive(32'h00800000, 32'h3F000000);
      drive(32'h0, 32'h0);
      drive(32'h0, 32'h0);
      check("mul_underflow", o_pixel, 32'h0);

      // Overflow to infinity.
      flush_reset();
      drive(32'h7F000000, 32'h7F000000);
      drive(32'h0, 32'h0);
      drive(32'h0, 32'h0);
      check("overflow_inf", o_pixel, 32'h7F800000);

      // inf * 0 gives NaN, which then sticks.
      flush_reset();
      drive(32'h7F800000, 32'h0);
      drive(32'h0, 32'h0);
      drive(32'h0, 32'h0);
      check("inf_x_zero", o_pixel, 32'h7FC00000);
      repeat (3) begin
         drive(32'h3F800000, 32'h40000000);
         check("nan_sticky", o_pixel, 32'h7FC00000);
      end

      // Mid-run reset after pair 4, then pairs 5..9 from zero.
      flush_reset();
      for (int i = 0; i < 4; i++) drive(dp_px[i], dp_wt[i]);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("midrun_rst", o_pixel, 32'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      i_pixel  = dp_px[4];
      i_weight = dp_wt[4];
      for (int i = 5; i < 9; i++) drive(dp_px[i], dp_wt[i]);
      drive(32'h0, 32'h0);
      check("midrun_200", o_pixel, 32'h43480000);
      drive(32'h0, 32'h0);
      check("midrun_209", o_pixel, 32'h43510000);

      // Random integer pixels, sixteenth-step signed weights (all exact).
      flush_reset();
      sum = 0;
      repeat (200) begin
         p = int'($urandom_range(0, 255));
         k = int'($urandom_range(0, 255)) - 128;
         drive(to_fp(p, 0), to_fp(k, 4));
         q.push_back(p * k);
         // Two pairs are always in flight ahead of the visible sum.
         while (q.size() > 2) sum += q.pop_front();
         check("rand", o_pixel, to_fp(sum, 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
